// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the request error check used at acceptance.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_STORE    = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_e;

  // Any hit in this chain makes the request complete with an error and no memory access.
  function automatic logic req_error(input logic [1:0]  size,
                                     input logic [31:0] addr,
                                     input int unsigned mem_words);
    logic err;
    if (size == SIZE_ILL) begin
      err = 1'b1;
    end else if ((size == SIZE_HALF) && addr[0]) begin
      err = 1'b1;
    end else if ((size == SIZE_WORD) && (addr[1:0] != 2'b00)) begin
      err = 1'b1;
    end else if ({2'b00, addr[31:2]} >= 32'(mem_words)) begin
      err = 1'b1;
    end else begin
      err = 1'b0;
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extract/extend a byte or half for loads and
// merge store data into a word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] data_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  shamt_s;
  logic [31:0] shifted_s;
  logic [31:0] mask_s;

  always_comb begin
    shamt_s   = {offset_i, 3'b000};
    shifted_s = word_i >> shamt_s;
    load_o    = word_i;
    mask_s    = 32'hFFFF_FFFF;
    case (size_i)
      SIZE_BYTE: begin
        load_o = {{24{signed_i & shifted_s[7]}}, shifted_s[7:0]};
        mask_s = 32'h0000_00FF << shamt_s;
      end
      SIZE_HALF: begin
        load_o = {{16{signed_i & shifted_s[15]}}, shifted_s[15:0]};
        mask_s = 32'h0000_FFFF << shamt_s;
      end
      default: begin
        load_o = word_i;
        mask_s = 32'hFFFF_FFFF;
      end
    endcase
    merge_o = (word_i & ~mask_s) | ((data_i << shamt_s) & mask_s);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator driving a word-indexed data memory,
// with byte/half lane handling and error flagging.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_e  state_q,  state_d;
  logic        write_q,  write_d;
  logic [1:0]  size_q,   size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q,   addr_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q,  rdata_d;
  logic        error_q,  error_d;
  logic        req_err_s;
  logic [31:0] load_s;
  logic [31:0] merge_s;

  lsu_lane_align u_align (
    .word_i   (mem_read_data),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_i   (wdata_q),
    .load_o   (load_s),
    .merge_o  (merge_s)
  );

  assign req_err_s = req_error(req_size, req_addr, MEM_WORDS);

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          merged_d = req_wdata;
          rdata_d  = 32'd0;
          error_d  = req_err_s;
          if (req_err_s) begin
            state_d = ST_RESP;
          end else if (!req_write) begin
            state_d = ST_LOAD;
          end else if (req_size == SIZE_WORD) begin
            state_d = ST_STORE;
          end else begin
            state_d = ST_RMW_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        rdata_d = load_s;
        state_d = ST_RESP;
      end
      ST_RMW_READ: begin
        merged_d = merge_s;
        state_d  = ST_STORE;
      end
      ST_STORE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Reset abandons any access in flight; the memory strobes decode from state_q and drop with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      merged_q <= 32'd0;
      rdata_q  <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign mem_read       = (state_q == ST_LOAD) || (state_q == ST_RMW_READ);
  assign mem_write      = (state_q == ST_STORE);
  assign mem_addr       = {2'b00, addr_q[31:2]};
  assign mem_write_data = merged_q;
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_error     = (state_q == ST_RESP) && error_q;
  assign resp_rdata     = rdata_q;

  logic unused_s;
  assign unused_s = write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a scoreboard queue of expected responses
// checked by an independent monitor, plus memory-strobe and reset checks.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        resp_valid, resp_error, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = 10'd0;
  logic [31:0] pl_val = 32'd0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_write && (mem_addr < 32'd1024)) mem[mem_addr[9:0]] <= mem_write_data;
  end
  assign mem_read_data = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'd0;

  typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } exp_t;
  exp_t sb[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;
  logic [31:0] last_waddr = 32'd0, last_wdata = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response pulse and tracks memory strobes.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++;
        last_waddr = mem_addr;
        last_wdata = mem_write_data;
      end
      if (mem_read && mem_write) chk("rd_wr_overlap", 32'd1, 32'd0);
      if (resp_valid) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat, input bit track);
    int n;
    exp_t e;
    @(negedge clk);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    if (track) begin
      e.rdata = erd; e.err = eerr; e.lat = elat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  int rd0, wr0, rc0;

  initial begin
    #3;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outs", {28'd0, mem_read, mem_write, resp_valid, resp_error}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Word store then load
    wr0 = wr_cnt; rd0 = rd_cnt;
    issue(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1'b1);
    drain();
    chk("wstore_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
    chk("wstore_rd_cnt", 32'(rd_cnt - rd0), 32'd0);
    chk("wstore_addr", last_waddr, 32'd4);
    chk("wstore_data", last_wdata, 32'hDEADBEEF);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    drain();

    // Byte store by read-modify-write
    preload(10'd4, 32'h11223344);
    wr0 = wr_cnt; rd0 = rd_cnt;
    issue(1'b1, SIZE_BYTE, 1'b0, 32'h12, 32'h000000AA, 32'd0, 1'b0, 3, 1'b1);
    drain();
    chk("bstore_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
    chk("bstore_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
    chk("bstore_data", last_wdata, 32'h11AA3344);
    chk("bstore_mem", mem[4], 32'h11AA3344);

    // Signed / unsigned loads and a half store
    preload(10'd4, 32'h80FF7F01);
    issue(1'b0, SIZE_BYTE, 1'b1, 32'h11, 32'd0, 32'h0000007F, 1'b0, 2, 1'b1);
    issue(1'b0, SIZE_BYTE, 1'b1, 32'h12, 32'd0, 32'hFFFFFFFF, 1'b0, 2, 1'b1);
    issue(1'b0, SIZE_HALF, 1'b0, 32'h12, 32'd0, 32'h000080FF, 1'b0, 2, 1'b1);
    issue(1'b0, SIZE_HALF, 1'b1, 32'h12, 32'd0, 32'hFFFF80FF, 1'b0, 2, 1'b1);
    issue(1'b0, SIZE_BYTE, 1'b0, 32'h13, 32'd0, 32'h00000080, 1'b0, 2, 1'b1);
    issue(1'b1, SIZE_HALF, 1'b0, 32'h10, 32'hFFFF1234, 32'd0, 1'b0, 3, 1'b1);
    issue(1'b0, SIZE_BYTE, 1'b1, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0, 2, 1'b1);
    drain();
    chk("hstore_mem", mem[4], 32'h80FF1234);

    // Errors never touch memory; last in-range word is legal
    wr0 = wr_cnt; rd0 = rd_cnt;
    issue(1'b0, SIZE_HALF, 1'b0, 32'h01,   32'd0, 32'd0, 1'b1, 1, 1'b1);
    issue(1'b1, SIZE_WORD, 1'b0, 32'h06,   32'h12345678, 32'd0, 1'b1, 1, 1'b1);
    issue(1'b0, SIZE_ILL,  1'b0, 32'h00,   32'd0, 32'd0, 1'b1, 1, 1'b1);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h1000, 32'd0, 32'd0, 1'b1, 1, 1'b1);
    drain();
    chk("err_rd_cnt", 32'(rd_cnt - rd0), 32'd0);
    chk("err_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
    preload(10'd1023, 32'hCAFEF00D);
    issue(1'b0, SIZE_WORD, 1'b0, 32'hFFC, 32'd0, 32'hCAFEF00D, 1'b0, 2, 1'b1);
    drain();

    // Reset during RMW_READ of a byte store
    preload(10'd5, 32'h55667788);
    wr0 = wr_cnt;
    issue(1'b1, SIZE_BYTE, 1'b0, 32'h14, 32'h00000099, 32'd0, 1'b0, 0, 1'b0);
    req_valid = 1'b0;
    #2;
    chk("mid_rmw_read", {31'd0, mem_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {28'd0, mem_read, mem_write, resp_valid, resp_error}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_wdata", mem_write_data, 32'd0);
    chk("mid_rst_rdata", resp_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
    chk("post_rst_mem", mem[5], 32'h55667788);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h14, 32'd0, 32'h55667788, 1'b0, 2, 1'b1);
    drain();

    // Back-to-back loads with req_valid held high
    preload(10'd6, 32'hA0A0A0A0);
    preload(10'd7, 32'hB1B2B3B4);
    preload(10'd8, 32'hC0FFEE00);
    rc0 = resp_cnt;
    issue(1'b0, SIZE_WORD, 1'b0, 32'h18, 32'd0, 32'hA0A0A0A0, 1'b0, 2, 1'b1);
    issue(1'b0, SIZE_BYTE, 1'b0, 32'h1D, 32'd0, 32'h000000B3, 1'b0, 2, 1'b1);
    issue(1'b0, SIZE_HALF, 1'b1, 32'h22, 32'd0, 32'hFFFFC0FF, 1'b0, 2, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    chk("b2b_resp_cnt", 32'(resp_cnt - rc0), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory interface.
- Accepts one byte-addressed load or store at a time from the pipeline and drives the word-indexed data memory port (addr, mem_read, mem_write, write_data, read_data).
- Handles byte and halfword accesses: lane extraction and sign extension for loads, read-modify-write for stores. Flags misaligned and out-of-range accesses.
- Sits between the execute stage and data memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the target memory; word index must be < MEM_WORDS.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- resp_error  out  1  valid with resp_valid: misaligned, illegal size or out of range
- mem_addr  out  32  word index = latched req_addr >> 2
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable; memory writes on the rising edge while high
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  combinational read data from memory

Behaviour:
- States: IDLE, LOAD, RMW_READ, STORE, RESP.
- Reset (async):
  - state goes to IDLE immediately.
  - mem_read, mem_write, resp_valid and resp_error are 0.
  - resp_rdata, mem_addr and mem_write_data are 0.
  - A write in progress is abandoned; mem_write drops in the same cycle, so no write lands after rst rises.
- IDLE:
  - req_ready=1 (high only in IDLE).
  - On req_valid, latch all req_* fields.
  - If error (see below) → RESP with error=1.
  - Otherwise, a load → LOAD; a word store → STORE; a byte/half store → RMW_READ.
- Error conditions, checked in priority order:
  - size=11
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - addr>>2 ≥ MEM_WORDS
  - An error never asserts mem_read or mem_write.
- LOAD:
  - mem_read=1.
  - Capture the lane selected by addr[1:0], little-endian (offset 0 = bits [7:0]), extended per req_signed, into resp_rdata.
  - → RESP.
- RMW_READ:
  - mem_read=1.
  - Register a merged word: mem_read_data with the target byte/half lane replaced by req_wdata low bits.
  - → STORE.
- STORE:
  - mem_write=1 for exactly one cycle.
  - mem_write_data = merged word, or req_wdata for word stores.
  - → RESP.
- RESP:
  - resp_valid=1 for one cycle; there is no response backpressure.
  - → IDLE.
  - req_ready=0 here, so a back-to-back request is accepted at earliest one cycle after RESP.
- Latency (acceptance edge → resp_valid high):
  - load: 2 cycles
  - word store: 2 cycles
  - byte/half store: 3 cycles
  - error: 1 cycle
- Outside LOAD and RMW_READ, mem_read=0. Outside STORE, mem_write=0. mem_read and mem_write are never both 1.
- req_* inputs are ignored when req_ready=0.

Decomposition:
- Shared package lsu_pkg contains:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD
  - state encodings
- One combinational sub-module, lsu_lane_align:
  - extract/extend path: (word, offset, size, signed) → result
  - merge path: (word, offset, size, data) → word

Test Plan:
- Word store then load: store 0xDEADBEEF at addr 0x10 → mem_write high one cycle with mem_addr=4; load word at 0x10 → resp_rdata=0xDEADBEEF, 2-cycle latency, resp_error=0.
- Byte store: memory word 4 = 0x11223344; store byte 0xAA at 0x12 → one mem_read cycle then one mem_write cycle with data 0x11AA3344; total latency 3.
- Signed/unsigned loads: word 4 = 0x80FF7F01. Expected results:
  - signed byte @0x11 → 0x0000007F
  - signed byte @0x12 → 0xFFFFFFFF
  - unsigned half @0x12 → 0x000080FF
  - signed half @0x12 → 0xFFFF80FF
- Errors: each of the following → resp_valid after 1 cycle, resp_error=1, mem_read and mem_write never asserted:
  - half load @0x01
  - word store @0x06
  - size=11
  - word load @0x1000 with MEM_WORDS=1024
- Reset mid-store: assert rst during RMW_READ of a byte store → mem_write never asserts, target word unchanged, all outputs 0, req_ready=1 after release.
- Back-to-back: req_valid held high with 3 queued loads → each accepted only when req_ready=1; exactly 3 resp_valid pulses with correct data in order.
